// File: rtl/fetch_unit_pkg.sv
// Shared types and sizing for the instruction fetch stage.
package fetch_unit_pkg;

  localparam int unsigned XLEN        = 64;
  localparam int unsigned FETCH_DEPTH = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Memory-port and decoder-side signals of the fetch stage, grouped for port binding.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic            flush_i;
  logic [XLEN-1:0] flush_pc_i;
  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_gnt_i;
  logic            imem_rvalid_i;
  logic [31:0]     imem_rdata_i;
  logic            fetch_valid_o;
  logic [XLEN-1:0] fetch_pc_o;
  logic [31:0]     fetch_instr_o;
  logic            fetch_ready_i;

  modport master (
    input  flush_i, flush_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, fetch_ready_i,
    output imem_req_o, imem_addr_o, fetch_valid_o, fetch_pc_o, fetch_instr_o
  );

  modport slave (
    output flush_i, flush_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, fetch_ready_i,
    input  imem_req_o, imem_addr_o, fetch_valid_o, fetch_pc_o, fetch_instr_o
  );

endinterface

// File: rtl/fetch_unit_chk.sv
// Protocol checks for the fetch stage memory port; no functional logic.
module fetch_unit_chk
  import fetch_unit_pkg::*;
#(
  parameter int unsigned PTR_W = 3
) (
  input logic             clk_i,
  input logic             rst_ni,
  input logic             flush,
  input logic             req,
  input logic             gnt,
  input logic [XLEN-1:0]  addr,
  input logic             rvalid,
  input logic [PTR_W-1:0] drop_cnt,
  input logic [PTR_W-1:0] pending
);

  a_resp_tracked: assert property (@(posedge clk_i) disable iff (!rst_ni)
    rvalid |-> ((drop_cnt != {PTR_W{1'b0}}) || (pending != {PTR_W{1'b0}})))
    else $error("imem response with no outstanding request");

  a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (req && !gnt && !flush) |=> (flush || (req && $stable(addr))))
    else $error("imem request dropped or changed before grant");

endmodule

// File: rtl/fetch_unit_queue.sv
// In-order fetch buffer: entries are reserved on grant, filled on response, read at the head.
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter  int unsigned DEPTH = FETCH_DEPTH,
  localparam int unsigned PTR_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush,
  input  logic             reserve,
  input  logic [XLEN-1:0]  reserve_pc,
  input  logic             fill,
  input  logic [31:0]      fill_instr,
  input  logic             pop,
  output logic             head_valid,
  output logic [XLEN-1:0]  head_pc,
  output logic [31:0]      head_instr,
  output logic [PTR_W-1:0] count,
  output logic [PTR_W-1:0] pending
);

  localparam int unsigned IDX_W = PTR_W - 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  fetch_entry_t     entries_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r, fill_ptr_r, rd_ptr_r;
  logic [IDX_W-1:0] wr_idx_s, fill_idx_s, rd_idx_s;

  assign wr_idx_s   = wr_ptr_r[IDX_W-1:0];
  assign fill_idx_s = fill_ptr_r[IDX_W-1:0];
  assign rd_idx_s   = rd_ptr_r[IDX_W-1:0];
  assign count      = wr_ptr_r - rd_ptr_r;
  assign pending    = wr_ptr_r - fill_ptr_r;
  assign head_valid = (count != {PTR_W{1'b0}}) && entries_r[rd_idx_s].filled;
  assign head_pc    = entries_r[rd_idx_s].pc;
  assign head_instr = entries_r[rd_idx_s].instr;

  // Reserve/fill/read pointer and entry updates; flush empties the queue.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      fill_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      entries_r  <= '{default: '0};
    end else if (flush) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      fill_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
    end else begin
      if (reserve) begin
        entries_r[wr_idx_s].pc     <= reserve_pc;
        entries_r[wr_idx_s].filled <= 1'b0;
        wr_ptr_r                   <= wr_ptr_r + PTR_ONE;
      end
      if (fill) begin
        entries_r[fill_idx_s].instr  <= fill_instr;
        entries_r[fill_idx_s].filled <= 1'b1;
        fill_ptr_r                   <= fill_ptr_r + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the fetch PC, request credit and stale-response drop counter.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] BOOT_ADDR = 64'h8000_0000,
  parameter int unsigned     DEPTH     = FETCH_DEPTH
) (
  input logic          clk_i,
  input logic          rst_ni,
  fetch_unit_if.master bus
);

  localparam int unsigned     PTR_W   = $clog2(DEPTH) + 1;
  localparam int unsigned     SUM_W   = PTR_W + 2;
  localparam logic [PTR_W:0]  DEPTH_U = (PTR_W + 1)'(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
  localparam logic [XLEN-1:0] PC_MASK = ~XLEN'(3);
  localparam logic [PTR_W-1:0] CNT_ONE = PTR_W'(1);

  logic [XLEN-1:0]  pc_r;
  logic [PTR_W-1:0] drop_cnt_r, count_s, pending_s;
  logic [PTR_W:0]   used_s;
  logic [SUM_W-1:0] drop_sum_s, drop_flush_s;
  logic             req_pend_s, req_s, gnt_fire_s, gnt_flush_s;
  logic             drop_resp_s, fill_s, pop_s, head_valid_s;

  // The un-flushed request still counts on flush: a grant for it means a response will come back.
  assign used_s       = {1'b0, count_s} + {1'b0, drop_cnt_r};
  assign req_pend_s   = rst_ni && (used_s < DEPTH_U);
  assign req_s        = req_pend_s && !bus.flush_i;
  assign gnt_fire_s   = req_s && bus.imem_gnt_i;
  assign gnt_flush_s  = req_pend_s && bus.imem_gnt_i;
  assign drop_resp_s  = bus.imem_rvalid_i && (drop_cnt_r != {PTR_W{1'b0}});
  assign fill_s       = bus.imem_rvalid_i && (drop_cnt_r == {PTR_W{1'b0}}) && !bus.flush_i;
  assign pop_s        = head_valid_s && bus.fetch_ready_i && !bus.flush_i;

  assign bus.imem_req_o    = req_s;
  assign bus.imem_addr_o   = pc_r;
  assign bus.fetch_valid_o = head_valid_s;

  // Outstanding requests that become stale on a redirect, clamped at zero.
  always_comb begin
    drop_sum_s = {2'b00, drop_cnt_r} + {2'b00, pending_s} + SUM_W'(gnt_flush_s);
    if (bus.imem_rvalid_i && (drop_sum_s == {SUM_W{1'b0}})) begin
      drop_flush_s = {SUM_W{1'b0}};
    end else begin
      drop_flush_s = drop_sum_s - SUM_W'(bus.imem_rvalid_i);
    end
  end

  // Fetch PC: redirect target or advance by one word per grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_r <= BOOT_ADDR;
    end else if (bus.flush_i) begin
      pc_r <= bus.flush_pc_i & PC_MASK;
    end else if (gnt_fire_s) begin
      pc_r <= pc_r + PC_STEP;
    end
  end

  // Count of responses still owed to requests older than the last redirect.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drop_cnt_r <= {PTR_W{1'b0}};
    end else if (bus.flush_i) begin
      drop_cnt_r <= drop_flush_s[PTR_W-1:0];
    end else if (drop_resp_s) begin
      drop_cnt_r <= drop_cnt_r - CNT_ONE;
    end
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush      (bus.flush_i),
    .reserve    (gnt_fire_s),
    .reserve_pc (pc_r),
    .fill       (fill_s),
    .fill_instr (bus.imem_rdata_i),
    .pop        (pop_s),
    .head_valid (head_valid_s),
    .head_pc    (bus.fetch_pc_o),
    .head_instr (bus.fetch_instr_o),
    .count      (count_s),
    .pending    (pending_s)
  );

  fetch_unit_chk #(.PTR_W(PTR_W)) u_chk (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .flush    (bus.flush_i),
    .req      (req_s),
    .gnt      (bus.imem_gnt_i),
    .addr     (pc_r),
    .rvalid   (bus.imem_rvalid_i),
    .drop_cnt (drop_cnt_r),
    .pending  (pending_s)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order memory model and an expected-PC stream.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic clk    = 1'b0;
  logic rst_ni = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit #(.BOOT_ADDR(64'h8000_0000), .DEPTH(4)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  typedef struct {
    logic [63:0] addr;
    int          due;
  } resp_t;

  resp_t       resp_q [$];
  int          cyc, last_due, gwait, gdelay, gmax, lat_min, lat_max, ready_mode;
  int          grants, pops, n_checks, n_pass;
  bit          force_gnt;
  logic [63:0] exp_pc, first_pc;
  logic        s_req, s_gnt, s_valid, s_ready, s_rvalid;
  logic [63:0] s_addr, s_pc;
  logic [31:0] s_instr;

  function automatic logic [31:0] memf(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hA5C3_0F1E;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  task automatic zero_inputs();
    bus.flush_i       = 1'b0;
    bus.flush_pc_i    = 64'h0;
    bus.imem_gnt_i    = 1'b0;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = 32'h0;
    bus.fetch_ready_i = 1'b0;
  endtask

  task automatic do_reset();
    zero_inputs();
    rst_ni = 1'b0;
    resp_q.delete();
    cyc = 0; last_due = 0; gwait = 0; gdelay = 0; force_gnt = 1'b0;
    pops = 0; grants = 0;
    exp_pc = 64'h8000_0000;
    #1;
    check_eq("rst_req",   64'(bus.imem_req_o), 64'h0);
    check_eq("rst_addr",  bus.imem_addr_o, 64'h8000_0000);
    check_eq("rst_valid", 64'(bus.fetch_valid_o), 64'h0);
    check_eq("rst_pc",    bus.fetch_pc_o, 64'h0);
    check_eq("rst_instr", 64'(bus.fetch_instr_o), 64'h0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
  endtask

  // One clock: drive at the negedge, sample just before the posedge, update the model after it.
  task automatic cycle(input bit fl, input logic [63:0] fpc);
    int lat, due;
    bus.flush_i       = fl;
    bus.flush_pc_i    = fpc;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = 32'h0;
    if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
      bus.imem_rvalid_i = 1'b1;
      bus.imem_rdata_i  = memf(resp_q[0].addr);
    end
    case (ready_mode)
      0:       bus.fetch_ready_i = 1'b0;
      1:       bus.fetch_ready_i = 1'b1;
      default: bus.fetch_ready_i = 1'($urandom_range(0, 1));
    endcase
    #1;
    bus.imem_gnt_i = force_gnt || (bus.imem_req_o && (gwait >= gdelay));
    #1;
    s_req = bus.imem_req_o;     s_gnt = bus.imem_gnt_i;       s_addr  = bus.imem_addr_o;
    s_valid = bus.fetch_valid_o; s_ready = bus.fetch_ready_i; s_rvalid = bus.imem_rvalid_i;
    s_pc = bus.fetch_pc_o;       s_instr = bus.fetch_instr_o;
    @(posedge clk);
    cyc++;
    if (s_rvalid) resp_q.delete(0);
    if (s_gnt) begin
      lat = int'($urandom_range(lat_min, lat_max));
      due = cyc + lat - 1;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      resp_q.push_back('{addr: s_addr, due: due});
      grants++;
      gwait  = 0;
      gdelay = int'($urandom_range(0, gmax));
    end else if (s_req) begin
      gwait++;
    end
    if (fl) begin
      exp_pc = fpc & ~64'h3;
    end else if (s_valid && s_ready) begin
      if (pops == 0) first_pc = s_pc;
      check_eq("pop_pc", s_pc, exp_pc);
      check_eq("pop_instr", 64'(s_instr), 64'(memf(exp_pc)));
      exp_pc = exp_pc + 64'h4;
      pops++;
    end
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    zero_inputs();
    gmax = 0; lat_min = 1; lat_max = 1; ready_mode = 1;
    #2;

    // Streaming: immediate grant, 1-cycle response.
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      cycle(1'b0, 64'h0);
      if (i == 1) check_eq("t1_req", 64'(s_req), 64'h1);
      if (i <= 3) begin
        check_eq("t1_addr", s_addr, 64'h8000_0000 + 64'(4 * (i - 1)));
        check_eq("t1_valid", 64'(s_valid), 64'(i == 3));
      end
    end
    check_eq("t1_pops", 64'(pops), 64'd18);

    // Backpressure: queue fills to DEPTH, then drains in order.
    ready_mode = 0;
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b0, 64'h0);
    check_eq("t2_grants", 64'(grants), 64'd4);
    check_eq("t2_req_off", 64'(s_req), 64'h0);
    check_eq("t2_no_pop", 64'(pops), 64'h0);
    ready_mode = 1;
    for (int i = 0; i < 10; i++) cycle(1'b0, 64'h0);
    check_eq("t2_pops", 64'(pops), 64'd10);

    // Redirect with three requests in flight.
    lat_min = 4; lat_max = 4;
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 64'h0);
    pops = 0;
    cycle(1'b1, 64'h1002);
    cycle(1'b0, 64'h0);
    check_eq("t3_addr", s_addr, 64'h1000);
    check_eq("t3_req", 64'(s_req), 64'h1);
    for (int i = 0; i < 20; i++) cycle(1'b0, 64'h0);
    check_eq("t3_first_pc", first_pc, 64'h1000);
    check_eq("t3_progress", 64'(pops > 0), 64'h1);

    // Redirect coinciding with a grant and a response.
    lat_min = 2; lat_max = 2;
    do_reset();
    cycle(1'b0, 64'h0);
    cycle(1'b0, 64'h0);
    pops = 0;
    force_gnt = 1'b1;
    cycle(1'b1, 64'h2000);
    force_gnt = 1'b0;
    check_eq("t4_rvalid_at_flush", 64'(s_rvalid), 64'h1);
    for (int i = 0; i < 20; i++) cycle(1'b0, 64'h0);
    check_eq("t4_first_pc", first_pc, 64'h2000);
    check_eq("t4_pops", 64'(pops), 64'd17);

    // Variable grant/response latency with random ready and a mid-run redirect.
    gmax = 5; lat_min = 1; lat_max = 6; ready_mode = 2;
    do_reset();
    for (int i = 0; i < 400; i++) cycle(i == 200, 64'h4000);
    ready_mode = 1;
    for (int i = 0; i < 60; i++) cycle(1'b0, 64'h0);
    check_eq("t5_progress", 64'(pops >= 50), 64'h1);

    // PC wrap at the top of the address space.
    gmax = 0; lat_min = 1; lat_max = 1; ready_mode = 1;
    do_reset();
    cycle(1'b0, 64'h0);
    cycle(1'b0, 64'h0);
    cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFFD);
    cycle(1'b0, 64'h0);
    check_eq("t6_addr_top", s_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    cycle(1'b0, 64'h0);
    check_eq("t6_addr_wrap", s_addr, 64'h0);
    pops = 0;
    for (int i = 0; i < 8; i++) cycle(1'b0, 64'h0);
    check_eq("t6_pops", 64'(pops >= 4), 64'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
